// File: rtl/mem_arbiter_if.sv
// Client and bus signal bundle of mem_arbiter.
// Ports: master = arbiter side, slave = the fetch/data clients plus the memory bus.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic                if_dummy_unused;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_sel;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    logic                bus_req;
    logic                bus_we;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic [DATA_W/8-1:0] bus_sel;
    logic [DATA_W-1:0]   bus_rdata;
    logic                bus_ack;
    logic                bus_err;

    logic stallreq_if;
    logic stallreq_mem;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        output mem_rdata, mem_ack,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err,
        input  bus_rdata, bus_ack,
        output stallreq_if, stallreq_mem
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        input  mem_rdata, mem_ack,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err,
        output bus_rdata, bus_ack,
        input  stallreq_if, stallreq_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and data memory.
// Ports: clk, rst (sync, active-high), arb (mem_arbiter_if.master: clients + bus).
// Optional macro ARB_TIMEOUT_EN adds a TIMEOUT-cycle bus_ack watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master arb
);
    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

    state_t            state;
    logic              last_mem;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              if_ack_q;
    logic              mem_ack_q;
    logic              expired;
    logic [DATA_W-1:0] rdata_in;

    logic if_go;
    logic mem_go;
    logic pick_mem;

    // A client whose ack is high this cycle is still holding the old request.
    assign if_go    = arb.if_req & ~if_ack_q;
    assign mem_go   = arb.mem_req & ~mem_ack_q;
    // MEM wins a tie unless it won the previous grant.
    assign pick_mem = mem_go & (~if_go | ~last_mem);
    // An abort returns zero data.
    assign rdata_in = arb.bus_ack ? arb.bus_rdata : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err_q;
    assign expired     = (cnt == CW'(TIMEOUT));
    assign arb.bus_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign expired        = 1'b0;
    assign arb.bus_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_mem    <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt         <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (if_go | mem_go) begin
                        req_q    <= 1'b1;
                        last_mem <= pick_mem;
`ifdef ARB_TIMEOUT_EN
                        cnt      <= '0;
`endif
                        if (pick_mem) begin
                            state   <= MEM_BUSY;
                            we_q    <= arb.mem_we;
                            addr_q  <= arb.mem_addr;
                            wdata_q <= arb.mem_wdata;
                            sel_q   <= arb.mem_sel;
                        end else begin
                            state   <= IF_BUSY;
                            we_q    <= 1'b0;
                            addr_q  <= arb.if_addr;
                            wdata_q <= '0;
                            sel_q   <= '1;
                        end
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    if (arb.bus_ack | expired) begin
                        req_q <= 1'b0;
                        state <= IDLE;
`ifdef ARB_TIMEOUT_EN
                        err_q <= ~arb.bus_ack;
`endif
                        if (state == IF_BUSY) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= rdata_in;
                        end else begin
                            mem_ack_q   <= 1'b1;
                            mem_rdata_q <= we_q ? '0 : rdata_in;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb.bus_req      = req_q;
    assign arb.bus_we       = we_q;
    assign arb.bus_addr     = addr_q;
    assign arb.bus_wdata    = wdata_q;
    assign arb.bus_sel      = sel_q;
    assign arb.if_rdata     = if_rdata_q;
    assign arb.if_ack       = if_ack_q;
    assign arb.mem_rdata    = mem_rdata_q;
    assign arb.mem_ack      = mem_ack_q;
    assign arb.stallreq_if  = arb.if_req & ~if_ack_q;
    assign arb.stallreq_mem = arb.mem_req & ~mem_ack_q;

endmodule
